// File: rtl/game_flow_ctrl.sv
// Top-level screen flow: centre-button debounce and MENU -> COUNTDOWN -> PLAYING -> MENU.
// Define GAME_FLOW_COUNTDOWN_EN to build the COUNTDOWN screen; without it MENU goes straight to PLAYING.
module game_flow_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_CYCLES     = 10,
  parameter int unsigned HOLD_CYCLES     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnC,
  input  logic       round_over,
  output logic       btn_pulse,
  output logic       game_start,
  output logic [1:0] screen_sel,
  output logic [1:0] countdown_val
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 1 || TICK_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("game_flow_ctrl: cycle-count parameters must be at least 1");
  end

  // Screen encoding doubles as the screen_sel value.
`ifdef GAME_FLOW_COUNTDOWN_EN
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  typedef enum logic [1:0] {
    ST_MENU      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAYING   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_MENU    = 2'd0,
    ST_PLAYING = 2'd2
  } state_t;
`endif

  state_t state, state_nxt;

  logic              s0, s1;
  logic              stable, stable_nxt;
  logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
  logic              armed, armed_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              hold_end;

`ifdef GAME_FLOW_COUNTDOWN_EN
  logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [1:0]        cd_val, cd_val_nxt;
`endif

  // Debounce: stable follows s1 only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_nxt = stable;
    db_cnt_nxt = '0;
    if (s1 != stable) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_nxt = s1;
      end else begin
        db_cnt_nxt = db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      stable    <= 1'b0;
      db_cnt    <= '0;
      btn_pulse <= 1'b0;
    end else begin
      s0        <= btnC;
      s1        <= s0;
      stable    <= stable_nxt;
      db_cnt    <= db_cnt_nxt;
      btn_pulse <= stable_nxt & ~stable;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_MENU;
      armed    <= 1'b0;
      hold_cnt <= '0;
`ifdef GAME_FLOW_COUNTDOWN_EN
      tick_cnt <= '0;
      cd_val   <= 2'd0;
`endif
    end else begin
      state    <= state_nxt;
      armed    <= armed_nxt;
      hold_cnt <= hold_cnt_nxt;
`ifdef GAME_FLOW_COUNTDOWN_EN
      tick_cnt <= tick_cnt_nxt;
      cd_val   <= cd_val_nxt;
`endif
    end
  end

  // Next-state logic; the hold abort arms only on a press seen while PLAYING.
  always_comb begin
    state_nxt    = state;
    armed_nxt    = armed;
    hold_cnt_nxt = hold_cnt;
    hold_end     = 1'b0;
`ifdef GAME_FLOW_COUNTDOWN_EN
    tick_cnt_nxt = tick_cnt;
    cd_val_nxt   = cd_val;
`endif
    case (state)
      ST_MENU: begin
        armed_nxt    = 1'b0;
        hold_cnt_nxt = '0;
        if (btn_pulse) begin
`ifdef GAME_FLOW_COUNTDOWN_EN
          state_nxt    = ST_COUNTDOWN;
          tick_cnt_nxt = '0;
          cd_val_nxt   = 2'd3;
`else
          state_nxt    = ST_PLAYING;
`endif
        end
      end
`ifdef GAME_FLOW_COUNTDOWN_EN
      ST_COUNTDOWN: begin
        if (tick_cnt == TICK_W'(TICK_CYCLES - 1)) begin
          tick_cnt_nxt = '0;
          if (cd_val == 2'd1) begin
            state_nxt  = ST_PLAYING;
            cd_val_nxt = 2'd0;
          end else begin
            cd_val_nxt = cd_val - 2'd1;
          end
        end else begin
          tick_cnt_nxt = tick_cnt + TICK_W'(1);
        end
      end
`endif
      ST_PLAYING: begin
        if (!stable) begin
          armed_nxt    = 1'b0;
          hold_cnt_nxt = '0;
        end else if (armed || btn_pulse) begin
          armed_nxt = 1'b1;
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_end = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        if (round_over || hold_end) begin
          state_nxt    = ST_MENU;
          armed_nxt    = 1'b0;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_MENU;
        armed_nxt    = 1'b0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Screen outputs registered from the next state so they move with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      game_start <= 1'b0;
      screen_sel <= 2'd0;
    end else begin
      game_start <= (state_nxt == ST_PLAYING);
      screen_sel <= 2'(state_nxt);
    end
  end

`ifdef GAME_FLOW_COUNTDOWN_EN
  assign countdown_val = cd_val;
`else
  assign countdown_val = 2'd0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios then random button/round_over traffic
// compared every cycle against a window/deadline based reference model.
module tb_game_flow_ctrl;

  localparam int D = 4;
  localparam int T = 10;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnC;
  logic       round_over;
  logic       btn_pulse;
  logic       game_start;
  logic [1:0] screen_sel;
  logic [1:0] countdown_val;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state (values as seen after each edge)
  int   n = 0;
  logic m_s0, m_s1, m_stable, m_pulse;
  logic win [D];
  int   m_scr, m_cd_left, m_abort_at;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btnC         (btnC),
    .round_over   (round_over),
    .btn_pulse    (btn_pulse),
    .game_start   (game_start),
    .screen_sel   (screen_sel),
    .countdown_val(countdown_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model update for one clock edge using the inputs the DUT sampled at that edge.
  task automatic model_edge();
    bit all_diff;
    n++;
    if (!reset) begin
      m_s0 = 0; m_s1 = 0; m_stable = 0; m_pulse = 0;
      for (int i = 0; i < D; i++) win[i] = 0;
      m_scr = 0; m_cd_left = 0; m_abort_at = -1;
      return;
    end
    case (m_scr)
      0: if (m_pulse) begin
`ifdef GAME_FLOW_COUNTDOWN_EN
        m_scr = 1; m_cd_left = 3 * T;
`else
        m_scr = 2; m_abort_at = -1;
`endif
      end
      1: begin
        m_cd_left--;
        if (m_cd_left == 0) begin m_scr = 2; m_abort_at = -1; end
      end
      default: begin
        if (m_pulse && m_abort_at < 0) m_abort_at = n + H - 1;
        if (!m_stable) m_abort_at = -1;
        if (round_over || (m_abort_at >= 0 && n == m_abort_at)) begin
          m_scr = 0; m_abort_at = -1;
        end
      end
    endcase
    // stable flips once the last D synchronised samples all disagree with it
    for (int i = D - 1; i > 0; i--) win[i] = win[i-1];
    win[0] = m_s1;
    all_diff = 1;
    for (int i = 0; i < D; i++) if (win[i] == m_stable) all_diff = 0;
    m_pulse = 0;
    if (all_diff) begin
      m_stable = ~m_stable;
      m_pulse  = m_stable;
    end
    m_s1 = m_s0;
    m_s0 = btnC;
  endtask

  task automatic check_outputs();
    int exp_cd;
    exp_cd = (m_scr == 1) ? (m_cd_left + T - 1) / T : 0;
    chk("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
    chk("game_start", 32'(game_start), 32'(m_scr == 2));
    chk("screen_sel", 32'(screen_sel), 32'(m_scr));
    chk("countdown_val", 32'(countdown_val), 32'(exp_cd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // From MENU with the button released: press, release, wait for PLAYING.
  task automatic go_playing();
    btnC = 1'b1;
    steps(D + 4);
    btnC = 1'b0;
    for (int k = 0; k < 6 * T + 20 && screen_sel != 2'd2; k++) step();
    chk("reach_playing", 32'(screen_sel), 32'd2);
    steps(D + 4);
  endtask

  initial begin
    int p, c, g, pulses, run;
    reset = 1'b0; btnC = 1'b1; round_over = 1'b0;

    // Reset held with button high: everything stays 0
    steps(3);
    chk("reset_screen", 32'(screen_sel), 32'd0);

    // Release reset: pulse appears D+1 edges after the first live sample
    reset = 1'b1;
    step();
    c = n;
    p = -1;
    for (int k = 0; k < 20 && p < 0; k++) begin
      step();
      if (btn_pulse) p = n;
    end
    chk("post_reset_pulse_lat", 32'(p - c), 32'(D + 1));

    // Button held from the menu press through PLAYING must never abort
    steps(3 * T + 2 * H + 10);
    chk("held_no_abort", 32'(screen_sel), 32'd2);

    // Hold abort: release, press again, MENU exactly H edges after stable rose
    btnC = 1'b0;
    steps(8);
    btnC = 1'b1;
    p = -1;
    for (int k = 0; k < 20 && p < 0; k++) begin
      step();
      if (btn_pulse) p = n;
    end
    g = -1;
    for (int k = 0; k < 2 * H && g < 0; k++) begin
      step();
      if (screen_sel == 2'd0) g = n;
    end
    chk("hold_abort_lat", 32'(g - p), 32'(H));
    steps(30 - H - D);
    btnC = 1'b0;
    steps(8);

    // Bounce shorter than D: no pulse, stays in MENU
    pulses = 0;
    for (int r = 0; r < 5; r++) begin
      btnC = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); pulses += int'(btn_pulse); end
      btnC = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); pulses += int'(btn_pulse); end
    end
    steps(6);
    chk("bounce_pulses", 32'(pulses), 32'd0);
    chk("bounce_screen", 32'(screen_sel), 32'd0);

    // Clean press: countdown dwell (or direct entry), round_over ignored in COUNTDOWN
    btnC = 1'b1;
    p = -1;
    for (int k = 0; k < 20 && p < 0; k++) begin
      step();
      if (btn_pulse) p = n;
    end
    btnC = 1'b0;
`ifdef GAME_FLOW_COUNTDOWN_EN
    step();
    chk("cd_entry", 32'(screen_sel), 32'd1);
    c = n;
    g = -1;
    for (int k = 0; k < 4 * T && g < 0; k++) begin
      round_over = (n == c + 5) ? 1'b1 : 1'b0;
      step();
      if (game_start) g = n;
    end
    round_over = 1'b0;
    chk("cd_dwell", 32'(g - c), 32'(3 * T));
`else
    step();
    chk("direct_play_lat", 32'(screen_sel), 32'd2);
`endif
    steps(D + 4);

    // round_over in PLAYING returns to MENU on the next edge
    round_over = 1'b1;
    step();
    round_over = 1'b0;
    chk("round_over_exit", 32'(screen_sel), 32'd0);
    steps(4);

    // round_over coincident with hold terminal: single MENU transition
    go_playing();
    btnC = 1'b1;
    for (int k = 0; k < H + 20; k++) begin
      if (m_abort_at >= 0 && m_abort_at == n + 1) break;
      step();
    end
    round_over = 1'b1;
    step();
    round_over = 1'b0;
    chk("coincident_exit", 32'(screen_sel), 32'd0);
    steps(10);
    chk("coincident_stay", 32'(screen_sel), 32'd0);
    btnC = 1'b0;
    steps(8);

    // Reset mid-countdown / mid-play discards progress
    btnC = 1'b1;
    steps(D + 6);
    reset = 1'b0;
    step();
    chk("mid_reset_cd", 32'(countdown_val), 32'd0);
    chk("mid_reset_screen", 32'(screen_sel), 32'd0);
    reset = 1'b1;
    btnC = 1'b0;
    steps(8);

    // Random traffic
    run = 0;
    for (int k = 0; k < 1500; k++) begin
      if (run == 0) begin
        btnC = 1'($urandom_range(0, 1));
        run  = int'($urandom_range(1, 30));
      end
      run--;
      round_over = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
      reset      = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1; round_over = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
